// File: rtl/riscv_base_trace_ctrl.sv
// rtl/riscv_base_trace_ctrl.sv - circular instruction trace buffer with PC trigger and post-trigger capture
module riscv_base_trace_ctrl #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       arm_i,
  input  logic                       abort_i,
  input  logic                       trig_en_i,
  input  logic [31:0]                trig_pc_i,
  input  logic                       valid_i,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                opcode_i,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [31:0]                rd_pc_o,
  output logic [31:0]                rd_opcode_o,
  output logic [1:0]                 state_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       triggered_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] post_cnt_q;
  logic [CW-1:0] count_q;
  logic [63:0]   mem_q [DEPTH];

  logic capture;
  logic trig_hit;
  logic full;
  logic pop;

  // Decode write, trigger, overwrite and pop conditions from current state
  always_comb begin
    capture    = 1'b0;
    trig_hit   = 1'b0;
    full       = (count_q == CW'(DEPTH));
    rd_valid_o = (state_q == S_READ) && (count_q != '0);
    pop        = 1'b0;
    if (!abort_i && valid_i && ((state_q == S_ARMED) || (state_q == S_POST))) begin
      capture = 1'b1;
    end
    if ((state_q == S_ARMED) && valid_i && (!trig_en_i || (pc_i == trig_pc_i))) begin
      trig_hit = 1'b1;
    end
    if (rd_valid_o && rd_ready_i && !abort_i) begin
      pop = 1'b1;
    end
  end

  // Trace storage; contents intentionally survive reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && capture) begin
      mem_q[wr_ptr_q] <= {pc_i, opcode_i};
    end
  end

  // Control FSM with pointers, occupancy and post-trigger countdown
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_cnt_q <= '0;
      count_q    <= '0;
    end else if (abort_i) begin
      state_q    <= S_IDLE;
      post_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            state_q  <= S_ARMED;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
          end
        end
        S_ARMED, S_POST: begin
          if (capture) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            // A full buffer drops its oldest entry, so the read side advances too
            if (full) begin
              rd_ptr_q <= rd_ptr_q + AW'(1);
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
          if (state_q == S_ARMED) begin
            if (trig_hit) begin
              post_cnt_q <= AW'(POST_TRIG);
              state_q    <= (POST_TRIG == 0) ? S_READ : S_POST;
            end
          end else if (capture) begin
            post_cnt_q <= post_cnt_q - AW'(1);
            if (post_cnt_q == AW'(1)) begin
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_q - CW'(1);
            if (count_q == CW'(1)) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_pc_o     = mem_q[rd_ptr_q][63:32];
  assign rd_opcode_o = mem_q[rd_ptr_q][31:0];
  assign state_o     = state_q;
  assign count_o     = count_q;
  assign triggered_o = (state_q == S_POST) || (state_q == S_READ);

endmodule

// File: tb/tb_riscv_base_trace_ctrl.sv
// tb/tb_riscv_base_trace_ctrl.sv - directed self-checking bench for riscv_base_trace_ctrl
module tb_riscv_base_trace_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        arm_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        trig_en_i = 1'b0;
  logic [31:0] trig_pc_i = '0;
  logic        valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] opcode_i = '0;
  logic        rd_ready_i = 1'b0;
  logic        rd_valid_o;
  logic [31:0] rd_pc_o;
  logic [31:0] rd_opcode_o;
  logic [1:0]  state_o;
  logic [4:0]  count_o;
  logic        triggered_o;

  int n_cmp = 0;
  int n_err = 0;

  riscv_base_trace_ctrl #(.DEPTH(16), .POST_TRIG(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .valid_i(valid_i),
    .pc_i(pc_i), .opcode_i(opcode_i), .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_o), .rd_pc_o(rd_pc_o), .rd_opcode_o(rd_opcode_o),
    .state_o(state_o), .count_o(count_o), .triggered_o(triggered_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input int st, input int cnt, input int rv, input int tr);
    check({tag, ".state"}, 64'(state_o), 64'(st));
    check({tag, ".count"}, 64'(count_o), 64'(cnt));
    check({tag, ".rd_valid"}, 64'(rd_valid_o), 64'(rv));
    check({tag, ".triggered"}, 64'(triggered_o), 64'(tr));
  endtask

  task automatic retire(input logic v, input logic [31:0] pc);
    valid_i  = v;
    pc_i     = pc;
    opcode_i = pc ^ 32'hA5A5_0000;
    step();
    valid_i  = 1'b0;
  endtask

  task automatic arm();
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    // Reset state
    step(); step();
    rst_i = 1'b0;
    check_status("reset", 0, 0, 0, 0);
    retire(1'b1, 32'h0000_0040);
    check_status("idle_ignore_valid", 0, 0, 0, 0);

    // Wrap: trigger on PC 0x124 (k=9), POST covers k=10..17
    trig_en_i = 1'b1;
    trig_pc_i = 32'h124;
    arm();
    check("wrap.armed", 64'(state_o), 64'd1);
    for (int k = 0; k < 20; k++) begin
      retire(1'b1, 32'h100 + 32'(4 * k));
      if (k == 8)  check("wrap.pre_trig_state", 64'(state_o), 64'd1);
      if (k == 9)  check("wrap.post_state", 64'(state_o), 64'd2);
      if (k == 16) check("wrap.still_post", 64'(state_o), 64'd2);
      if (k == 17) check_status("wrap.read", 3, 16, 1, 1);
    end
    check_status("wrap.late_ignored", 3, 16, 1, 1);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc = 32'h108 + 32'(4 * i);
      check("wrap.rd_pc", 64'(rd_pc_o), 64'(pc));
      check("wrap.rd_op", 64'(rd_opcode_o), 64'(pc ^ 32'hA5A5_0000));
      step();
    end
    rd_ready_i = 1'b0;
    check_status("wrap.drained", 0, 0, 0, 0);

    // Immediate trigger with gaps in POST
    trig_en_i = 1'b0;
    arm();
    retire(1'b1, 32'h2000);
    check_status("imm.post", 2, 1, 0, 1);
    retire(1'b1, 32'h2004);
    retire(1'b0, 32'hDEAD_0000);
    retire(1'b0, 32'hDEAD_0004);
    retire(1'b1, 32'h2008);
    check_status("gap.post", 2, 3, 0, 1);
    arm();
    check_status("gap.arm_ignored", 2, 3, 0, 1);
    for (int j = 3; j < 8; j++) retire(1'b1, 32'h2000 + 32'(4 * j));
    check_status("gap.one_left", 2, 8, 0, 1);
    retire(1'b1, 32'h2020);
    check_status("imm.read", 3, 9, 1, 1);
    for (int j = 9; j < 12; j++) retire(1'b1, 32'h2000 + 32'(4 * j));
    check_status("imm.ignored", 3, 9, 1, 1);

    // Backpressure: three stalled cycles then one pop per cycle
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp.stall_pc", 64'(rd_pc_o), 64'h2000);
      check("bp.stall_count", 64'(count_o), 64'd9);
    end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("bp.rd_pc", 64'(rd_pc_o), 64'(32'h2000 + 32'(4 * i)));
      step();
      if (i < 8) check("bp.count", 64'(count_o), 64'(8 - i));
    end
    rd_ready_i = 1'b0;
    check_status("bp.idle", 0, 0, 0, 0);

    // Abort with simultaneous arm in POST
    arm();
    retire(1'b1, 32'h4000);
    retire(1'b1, 32'h4004);
    retire(1'b1, 32'h4008);
    check_status("abort.pre", 2, 3, 0, 1);
    abort_i = 1'b1;
    arm_i   = 1'b1;
    valid_i = 1'b1;
    step();
    abort_i = 1'b0;
    arm_i   = 1'b0;
    valid_i = 1'b0;
    check_status("abort.post", 0, 0, 0, 0);
    step();
    check_status("abort.no_rearm", 0, 0, 0, 0);

    // Reset mid-READ with five entries left, then recapture
    arm();
    for (int j = 0; j < 9; j++) retire(1'b1, 32'h5000 + 32'(4 * j));
    check_status("rst.read", 3, 9, 1, 1);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rd_ready_i = 1'b0;
    check_status("rst.five_left", 3, 5, 1, 1);
    check("rst.rd_pc", 64'(rd_pc_o), 64'h5010);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_status("rst.after", 0, 0, 0, 0);
    trig_en_i = 1'b1;
    trig_pc_i = 32'h3010;
    arm();
    for (int j = 0; j < 13; j++) retire(1'b1, 32'h3000 + 32'(4 * j));
    check_status("rearm.read", 3, 13, 1, 1);
    check("rearm.rd_pc", 64'(rd_pc_o), 64'h3000);
    check("rearm.rd_op", 64'(rd_opcode_o), 64'(32'h3000 ^ 32'hA5A5_0000));
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_status("final.abort", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
